// File: rtl/stage_wb_pkg.sv
// Shared types and constants for the write-back stage.
// Load funct3 codes, hold-FSM states and the MEM/WB bundle.
package stage_wb_pkg;

   localparam int WB_XLEN  = 32;
   localparam int WB_ABITS = 5;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic {
      WB_PASS = 1'b0,
      WB_HOLD = 1'b1
   } wb_state_t;

   typedef struct packed {
      logic [WB_XLEN-1:0]  alu_o;
      logic [WB_ABITS-1:0] rd;
      logic [2:0]          func3;
      logic                mem_read;
      logic                reg_write;
      logic                valid;
   } mem_wb_t;

endpackage

// File: rtl/stage_wb_load_extract.sv
// Load data alignment: picks byte/half/word from the dmem word
// and sign- or zero-extends it according to funct3.
module load_extract
   import stage_wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  func3,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[{off, 3'b000} +: 8];
      // half select ignores off[0], same as the store side
      h = off[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data = '0;
      unique case (1'b1)
         (func3 == LB):  data = {{24{b[7]}}, b};
         (func3 == LH):  data = {{16{h[15]}}, h};
         (func3 == LW):  data = word;
         (func3 == LBU): data = {24'd0, b};
         (func3 == LHU): data = {16'd0, h};
         default:        data = '0;
      endcase
   end

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB register, load-data hold FSM and
// register-file write port (also the store-data forwarding source).
module stage_wb
   import stage_wb_pkg::*;
#(
   parameter int XLEN     = WB_XLEN,
   parameter int RF_ABITS = WB_ABITS
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [XLEN-1:0]     me_alu_o,
   input  logic                me_mem_read,
   input  logic                me_reg_write,
   input  logic [RF_ABITS-1:0] me_rd,
   input  logic [2:0]          me_func3_code,
   input  logic                page_fault,
   input  logic [XLEN-1:0]     me_mem_data,
   input  logic                wb_stall,
   input  logic                wb_flush,
   output logic                w_regs_en,
   output logic [RF_ABITS-1:0] w_regs_addr,
   output logic [XLEN-1:0]     w_regs_data,
   output logic                wb_valid
);

   mem_wb_t         wb_q, wb_d;
   wb_state_t       state_q, state_d;
   logic [XLEN-1:0] hold_q, hold_d;
   logic [XLEN-1:0] ld_src;
   logic [XLEN-1:0] ld_data;

   always_comb begin
      wb_d = wb_q;
      if (wb_flush) begin
         wb_d = '0;
      end else if (!wb_stall) begin
         wb_d.alu_o     = me_alu_o;
         wb_d.rd        = me_rd;
         wb_d.func3     = me_func3_code;
         wb_d.mem_read  = me_mem_read & ~page_fault;
         wb_d.reg_write = me_reg_write & ~page_fault;
         wb_d.valid     = ~page_fault;
      end
   end

   // dmem output is only valid for one cycle; latch it on a stall
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         WB_PASS: begin
            if (wb_stall && wb_q.mem_read && !wb_flush) begin
               state_d = WB_HOLD;
               hold_d  = me_mem_data;
            end
         end
         WB_HOLD: begin
            if (!wb_stall || wb_flush) state_d = WB_PASS;
         end
         default: state_d = WB_PASS;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb_q    <= '0;
         state_q <= WB_PASS;
         hold_q  <= '0;
      end else begin
         wb_q    <= wb_d;
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   assign ld_src = (state_q == WB_HOLD) ? hold_q : me_mem_data;

   load_extract u_ext (
      .word  (ld_src),
      .off   (wb_q.alu_o[1:0]),
      .func3 (wb_q.func3),
      .data  (ld_data)
   );

   assign w_regs_data = wb_q.mem_read ? ld_data : wb_q.alu_o;
   assign w_regs_addr = wb_q.rd;
   assign w_regs_en   = wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);
   assign wb_valid    = wb_q.valid;

endmodule

// File: tb/tb_stage_wb.sv
// Scoreboard bench for stage_wb: a reference model pushes expected
// write-port values, popped and compared one cycle after issue.
module tb_stage_wb;
   import stage_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] me_alu_o;
   logic        me_mem_read;
   logic        me_reg_write;
   logic [4:0]  me_rd;
   logic [2:0]  me_func3_code;
   logic        page_fault;
   logic [31:0] me_mem_data;
   logic        wb_stall;
   logic        wb_flush;
   logic        w_regs_en;
   logic [4:0]  w_regs_addr;
   logic [31:0] w_regs_data;
   logic        wb_valid;

   stage_wb dut (
      .clk           (clk),
      .rstn          (rstn),
      .me_alu_o      (me_alu_o),
      .me_mem_read   (me_mem_read),
      .me_reg_write  (me_reg_write),
      .me_rd         (me_rd),
      .me_func3_code (me_func3_code),
      .page_fault    (page_fault),
      .me_mem_data   (me_mem_data),
      .wb_stall      (wb_stall),
      .wb_flush      (wb_flush),
      .w_regs_en     (w_regs_en),
      .w_regs_addr   (w_regs_addr),
      .w_regs_data   (w_regs_data),
      .wb_valid      (wb_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        valid;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [31:0] m_alu;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;
   logic        m_mr, m_rw, m_v;
   logic        m_hold_st;
   logic [31:0] m_hold, m_dat;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w,
                                            input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] b;
      logic [31:0] h;
      b = w >> (8 * off);
      h = w >> (16 * off[1]);
      case (f3)
         3'd0:    return {{24{b[7]}}, b[7:0]};
         3'd1:    return {{16{h[15]}}, h[15:0]};
         3'd2:    return w;
         3'd4:    return {24'd0, b[7:0]};
         3'd5:    return {16'd0, h[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_alu = 0; m_rd = 0; m_f3 = 0;
      m_mr = 0; m_rw = 0; m_v = 0;
      m_hold_st = 0; m_hold = 0;
   endtask

   task automatic drive(input logic [31:0] alu, input logic mr,
                        input logic rw, input logic [4:0] rd,
                        input logic [2:0] f3, input logic pf,
                        input logic stall, input logic flush,
                        input logic [31:0] word);
      exp_t        e;
      logic [31:0] src;
      me_alu_o = alu; me_mem_read = mr; me_reg_write = rw;
      me_rd = rd; me_func3_code = f3; page_fault = pf;
      wb_stall = stall; wb_flush = flush;
      if (!m_hold_st) begin
         if (stall && m_mr && !flush) begin
            m_hold_st = 1; m_hold = m_dat;
         end
      end else if (!stall || flush) begin
         m_hold_st = 0;
      end
      if (flush) begin
         m_alu = 0; m_rd = 0; m_f3 = 0;
         m_mr = 0; m_rw = 0; m_v = 0;
      end else if (!stall) begin
         m_alu = alu; m_rd = rd; m_f3 = f3;
         m_mr = mr & ~pf; m_rw = rw & ~pf; m_v = ~pf;
      end
      @(posedge clk);
      #1;
      me_mem_data = word;
      m_dat = word;
      src = m_hold_st ? m_hold : m_dat;
      e.en    = m_v & m_rw & (m_rd != 0);
      e.addr  = m_rd;
      e.data  = m_mr ? ref_load(src, m_alu[1:0], m_f3) : m_alu;
      e.valid = m_v;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("en", w_regs_en, e.en);
         check("addr", w_regs_addr, e.addr);
         check("data", w_regs_data, e.data);
         check("valid", wb_valid, e.valid);
         check("state", dut.state_q, m_hold_st);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_en"}, w_regs_en, 0);
      check({tag, "_addr"}, w_regs_addr, 0);
      check({tag, "_data"}, w_regs_data, 0);
      check({tag, "_valid"}, wb_valid, 0);
      check({tag, "_state"}, dut.state_q, 0);
   endtask

   initial begin
      rstn = 0;
      me_alu_o = 0; me_mem_read = 0; me_reg_write = 0;
      me_rd = 0; me_func3_code = 0; page_fault = 0;
      me_mem_data = 0; wb_stall = 0; wb_flush = 0;
      model_reset();
      m_dat = 0;
      #3;
      check_zero("reset");
      @(negedge clk);
      rstn = 1;

      drive(32'h1003, 1, 1, 3, LB,  0, 0, 0, 32'h80FF1234);
      drive(32'h1003, 1, 1, 4, LBU, 0, 0, 0, 32'h80FF1234);
      drive(32'h2002, 1, 1, 5, LH,  0, 0, 0, 32'h80FF1234);
      drive(32'h2000, 1, 1, 6, LHU, 0, 0, 0, 32'h80FF1234);
      drive(32'h3001, 1, 1, 7, LW,  0, 0, 0, 32'hCAFEF00D);
      drive(32'h55AA, 0, 1, 8, 3'd0, 0, 0, 0, 32'hFFFFFFFF);
      drive(32'h0004, 1, 1, 9, 3'b011, 0, 0, 0, 32'h12345678);
      drive(32'h0040, 0, 1, 5, 3'd0, 1, 0, 0, 32'h0);
      drive(32'h0077, 0, 1, 0, 3'd0, 0, 0, 0, 32'h0);

      drive(32'h4000, 1, 1, 9, LW, 0, 0, 0, 32'h12345678);
      for (int i = 0; i < 3; i++)
         drive(32'h0BAD, 0, 1, 10, 3'd0, 0, 1, 0, 32'hDEADBEEF);
      drive(32'h0011, 0, 1, 11, 3'd0, 0, 0, 0, 32'hDEADBEEF);

      drive(32'h5000, 1, 1, 12, LW, 0, 0, 0, 32'h11112222);
      drive(32'h0BAD, 0, 1, 10, 3'd0, 0, 1, 0, 32'h33334444);
      drive(32'h0BAD, 0, 1, 10, 3'd0, 0, 1, 1, 32'h55556666);

      for (int i = 0; i < 60; i++)
         drive($urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
               $urandom);

      drive(32'h6000, 1, 1, 13, LW, 0, 0, 0, 32'hA5A5A5A5);
      drive(32'h0BAD, 0, 1, 10, 3'd0, 0, 1, 0, 32'h0);
      check("hold_before_rst", dut.state_q, 1);
      #2;
      rstn = 0;
      #1;
      check_zero("async_rst");
      @(negedge clk);
      rstn = 1;
      wb_stall = 0;
      model_reset();
      drive(32'h0077, 0, 1, 1, 3'd0, 0, 0, 0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
